button_event_detector: RTL and testbench
========================================

BUTTON_EVENT_DETECTOR -- requirements
Module: button_event_detector

Interface
REQ-001 The block SHALL have parameter LONG_TICKS, default 1000, giving the tick count at which a held press becomes a long press.
REQ-002 The block SHALL have parameter DCLICK_TICKS, default 250, giving the tick window after a release in which a second press counts as a double click.
REQ-003 The block SHALL have parameter CNT_W, default 10, giving the width of the tick counter.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 debounced  input  1  clean, clk-synchronous button level from the upstream debouncer.
REQ-007 tick  input  1  one-clk timebase strobe (for example 1 ms).
REQ-008 rise  output  1  one-clk pulse on a 0->1 transition of debounced.
REQ-009 fall  output  1  one-clk pulse on a 1->0 transition of debounced.
REQ-010 short_press  output  1  one-clk pulse for a single short press.
REQ-011 long_press  output  1  one-clk pulse when a press reaches LONG_TICKS.
REQ-012 double_click  output  1  one-clk pulse on the second press of a double click.
REQ-013 held  output  1  level, high while in state LONG.

Function
REQ-014 Edge detection SHALL use a 1-bit register d_q of debounced: rise_ev = debounced & ~d_q; fall_ev = ~debounced & d_q.
REQ-015 rise and fall SHALL be registered copies of rise_ev and fall_ev, with latency 1 clk and width exactly 1 clk.
REQ-016 The FSM SHALL act on rise_ev and fall_ev in the cycle they are detected; all event outputs SHALL be registered, so each appears 1 clk after its causing edge or tick.
REQ-017 The FSM SHALL have states IDLE, PRESS1, LONG, WAIT2 and PRESS2.
REQ-018 Any state transition SHALL clear cnt; otherwise cnt SHALL increment on tick and saturate at 2^CNT_W-1.
REQ-019 IDLE: rise_ev -> PRESS1.
REQ-020 PRESS1: fall_ev -> WAIT2; else tick with cnt==LONG_TICKS-1 -> LONG and pulse long_press.
REQ-021 LONG: held=1; fall_ev -> IDLE; no short_press SHALL be issued.
REQ-022 WAIT2: rise_ev -> PRESS2 and pulse double_click; else tick with cnt==DCLICK_TICKS-1 -> IDLE and pulse short_press.
REQ-023 PRESS2: fall_ev -> IDLE; no long detection in PRESS2.
REQ-024 Simultaneous edge and tick in the same cycle: the edge SHALL take priority and the tick SHALL be ignored.
REQ-025 At most one of short_press, long_press and double_click SHALL be high in any cycle.
REQ-026 Illegal state encodings SHALL return to IDLE on the next clk.
REQ-027 CNT_W SHALL satisfy 2^CNT_W > max(LONG_TICKS, DCLICK_TICKS); the bench SHALL check this at elaboration.

Reset
REQ-028 While reset_n=0, state SHALL be IDLE, cnt=0, d_q=0, and every output SHALL be 0.
REQ-029 Reset asserted mid-press SHALL abandon the gesture with no event pulse.
REQ-030 If debounced=1 at reset release, one rise SHALL occur in the first active cycle and the FSM SHALL enter PRESS1.

Structure
REQ-031 A shared package/include (button_event_pkg) SHALL hold the state encodings (3-bit localparams) and default timing constants.
REQ-032 Edge detection SHALL be a sub-module named edge_detector (d_q register plus registered rise/fall); the FSM and counter SHALL remain in the top module.

Verification
Parameters for all scenarios: LONG_TICKS=4, DCLICK_TICKS=3, CNT_W=3, tick every 4th clk.
REQ-033 Short press: debounced high for 2 ticks, then low for more than 3 ticks -> rise, fall, then one short_press pulse at the 3rd tick after release; no other events.
REQ-034 Long press: debounced high for 6 ticks -> long_press pulse at the 4th tick; held high from then until 1 clk after fall; no short_press.
REQ-035 Double click: press 1 tick, release 1 tick, press again -> double_click pulse 1 clk after the second rise; no short_press; after the second fall the FSM is back in IDLE.
REQ-036 Edge/tick collision: fall coincident with the tick where cnt==3 in PRESS1 -> WAIT2 entered, no long_press.
REQ-037 Reset mid-press: reset_n low for 2 clks in PRESS1 at cnt=2 -> all outputs 0; with debounced still high after release, one rise pulse and counting restarts from 0.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared state encodings and default timing for the button event detector.
package button_event_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_WAIT2  = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_PRESS1 = ST_PRESS1,
    S_LONG   = ST_LONG,
    S_WAIT2  = ST_WAIT2,
    S_PRESS2 = ST_PRESS2
  } state_t;

  localparam int DEF_LONG_TICKS   = 1000;
  localparam int DEF_DCLICK_TICKS = 250;
  localparam int DEF_CNT_W        = 10;

endpackage

// File: rtl/button_event_detector_edge_detector.sv
// Edge detector: one-cycle-delayed copy of the button level, with combinational
// edge events for the FSM and registered rise/fall pulses for the outputs.
module edge_detector (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced,
  output logic rise_ev,
  output logic fall_ev,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_comb begin
    rise_ev = debounced & ~d_q;
    fall_ev = ~debounced & d_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      d_q  <= debounced;
      rise <= rise_ev;
      fall <= fall_ev;
    end
  end

endmodule

// File: rtl/button_event_detector.sv
// Classifies debounced button activity into short press, long press and
// double click using a tick-driven counter and a five-state gesture FSM.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced,
  input  logic tick,
  output logic rise,
  output logic fall,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic       rise_ev;
  logic       fall_ev;
  state_t     state;
  state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic       short_nxt;
  logic       long_nxt;
  logic       dclick_nxt;

  edge_detector u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .debounced (debounced),
    .rise_ev   (rise_ev),
    .fall_ev   (fall_ev),
    .rise      (rise),
    .fall      (fall)
  );

  // Edges are tested before ticks so a coincident tick is ignored.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    dclick_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise_ev) state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (fall_ev) begin
          state_nxt = S_WAIT2;
        end else if (tick && cnt == LONG_LAST) begin
          state_nxt = S_LONG;
          long_nxt  = 1'b1;
        end
      end
      S_LONG: begin
        if (fall_ev) state_nxt = S_IDLE;
      end
      S_WAIT2: begin
        if (rise_ev) begin
          state_nxt  = S_PRESS2;
          dclick_nxt = 1'b1;
        end else if (tick && cnt == DCLICK_LAST) begin
          state_nxt = S_IDLE;
          short_nxt = 1'b1;
        end
      end
      S_PRESS2: begin
        if (fall_ev) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
    end else begin
      state        <= state_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dclick_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  always_comb begin
    held = (state == S_LONG);
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Randomized and directed bench for button_event_detector, checked cycle by
// cycle against a gesture-level reference model.
module tb_button_event_detector;

  localparam int LT = 4;
  localparam int DT = 3;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic debounced;
  logic tick;
  logic rise, fall, short_press, long_press, double_click, held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // gesture-level reference state
  logic       prev_lvl;
  int         presses;
  logic       is_long;
  int         ticks;
  logic [5:0] exp_out;

  int c_rise, c_fall, c_sp, c_lp, c_dc, c_held;

  button_event_detector #(
    .LONG_TICKS   (LT),
    .DCLICK_TICKS (DT),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .debounced    (debounced),
    .tick         (tick),
    .rise         (rise),
    .fall         (fall),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held)
  );

  always #5 clk = ~clk;

  if ((1 << CW) <= ((LT > DT) ? LT : DT)) begin : g_cnt_w_bad
    initial begin
      $display("FAIL cnt_w_check: 2^CNT_W=%0d must exceed %0d", 1 << CW, (LT > DT) ? LT : DT);
      $fatal(1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model works on presses-in-gesture plus the button level rather than FSM states.
  task automatic model_update();
    logic r, f, sp, lp, dc;
    if (!reset_n) begin
      prev_lvl = 1'b0;
      presses  = 0;
      is_long  = 1'b0;
      ticks    = 0;
      exp_out  = '0;
      return;
    end
    r  = debounced && !prev_lvl;
    f  = !debounced && prev_lvl;
    sp = 1'b0;
    lp = 1'b0;
    dc = 1'b0;
    if (presses == 0) begin
      if (r) begin
        presses = 1;
        is_long = 1'b0;
        ticks   = 0;
      end
    end else if (presses == 1 && prev_lvl) begin
      if (f) begin
        if (is_long) presses = 0;
        else ticks = 0;
      end else if (tick && !is_long) begin
        ticks++;
        if (ticks == LT) begin
          is_long = 1'b1;
          lp      = 1'b1;
        end
      end
    end else if (presses == 1) begin
      if (r) begin
        presses = 2;
        dc      = 1'b1;
      end else if (tick) begin
        ticks++;
        if (ticks == DT) begin
          presses = 0;
          sp      = 1'b1;
        end
      end
    end else begin
      if (f) presses = 0;
    end
    prev_lvl = debounced;
    exp_out  = {r, f, sp, lp, dc, (presses == 1) && is_long && prev_lvl};
  endtask

  task automatic step(input logic d, input logic rn);
    @(negedge clk);
    chk("outs", {26'd0, rise, fall, short_press, long_press, double_click, held},
        {26'd0, exp_out});
    chk("onehot_events", 32'($onehot0({short_press, long_press, double_click})), 32'd1);
    c_rise += int'(rise);
    c_fall += int'(fall);
    c_sp   += int'(short_press);
    c_lp   += int'(long_press);
    c_dc   += int'(double_click);
    c_held += int'(held);
    debounced = d;
    reset_n   = rn;
    tick      = (cyc % 4 == 3);
    cyc++;
    model_update();
  endtask

  task automatic hold(input logic d, input int n_ticks);
    for (int i = 0; i < n_ticks * 4; i++) step(d, 1'b1);
  endtask

  task automatic align();
    while (cyc % 4 != 0) step(debounced, 1'b1);
  endtask

  task automatic clr_counts();
    c_rise = 0; c_fall = 0; c_sp = 0; c_lp = 0; c_dc = 0; c_held = 0;
  endtask

  initial begin
    debounced = 1'b0;
    tick      = 1'b0;
    reset_n   = 1'b0;
    model_update();
    clr_counts();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    hold(1'b0, 1);

    // short press
    clr_counts();
    hold(1'b1, 2);
    hold(1'b0, 5);
    chk("short_sp", c_sp, 1);
    chk("short_rise_fall", {16'(c_rise), 16'(c_fall)}, {16'd1, 16'd1});
    chk("short_lp_dc", {16'(c_lp), 16'(c_dc)}, 32'd0);

    // long press
    clr_counts();
    hold(1'b1, 6);
    hold(1'b0, 5);
    chk("long_lp", c_lp, 1);
    chk("long_sp", c_sp, 0);
    chk("long_held_seen", 32'(c_held > 0), 32'd1);

    // double click, then a short press proves the FSM returned to idle
    clr_counts();
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 5);
    chk("dclick_dc", c_dc, 1);
    chk("dclick_sp", c_sp, 0);
    clr_counts();
    hold(1'b1, 1);
    hold(1'b0, 5);
    chk("after_dclick_sp", c_sp, 1);

    // fall coincident with the tick that would complete a long press
    align();
    clr_counts();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    hold(1'b0, 5);
    chk("collide_lp", c_lp, 0);
    chk("collide_sp", c_sp, 1);

    // reset mid-press at cnt=2, button still held afterwards
    align();
    hold(1'b1, 2);
    clr_counts();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_outs_zero", c_rise + c_fall + c_sp + c_lp + c_dc + c_held, 0);
    hold(1'b1, 5);
    hold(1'b0, 5);
    chk("reset_rise", c_rise, 1);
    chk("reset_restart_lp", c_lp, 1);
    chk("reset_sp", c_sp, 0);

    // random activity with occasional resets
    for (int g = 0; g < 150; g++) begin
      logic d;
      int   n;
      d = 1'($urandom % 2);
      n = int'($urandom_range(1, 24));
      for (int k = 0; k < n; k++) step(d, 1'b1);
      if ($urandom % 20 == 0) begin
        step(d, 1'b0);
        step(d, 1'b0);
      end
    end
    hold(1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
